// File: rtl/fifo_frame_reader.sv
// Reads a standard-mode (1-cycle latency) FIFO and emits header + FRAME_LEN data word frames on a valid/ready stream.
// Optional trailer checksum word: define FRAME_READER_CHECKSUM_EN.
module fifo_frame_reader #(
    parameter int          DATA_WIDTH = 32,
    parameter int          FRAME_LEN  = 256,
    parameter logic [15:0] HEADER_TAG = 16'hA5A5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_RE,
    input  logic [DATA_WIDTH-1:0] FIFO_Q,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  M_LAST,
    output logic                  BUSY,
    output logic [15:0]           FRAME_SEQ
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TRL} state_t;

    localparam logic [15:0] LEN      = 16'(FRAME_LEN);
    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t                state_q, state_d;
    logic [15:0]           seq_q, seq_d;
    logic [15:0]           req_q, req_d;
    logic [15:0]           sent_q, sent_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  pop;
`ifdef FRAME_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

    // Frame sequencing, stream outputs and read request generation.
    // NOTE: every output and next-state value is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        req_d   = req_q;
        sent_d  = sent_q;
        M_DATA  = '0;
        M_VALID = 1'b0;
        M_LAST  = 1'b0;
        FIFO_RE = 1'b0;
`ifdef FRAME_READER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ENABLE) state_d = S_HDR;
            end
            S_HDR: begin
                M_DATA  = DATA_WIDTH'({HEADER_TAG, seq_q});
                M_VALID = 1'b1;
`ifdef FRAME_READER_CHECKSUM_EN
                chk_d   = '0;
`endif
                if (M_READY) begin
                    state_d = S_BODY;
                    req_d   = '0;
                    sent_d  = '0;
                end
            end
            S_BODY: begin
                M_DATA  = buf0_q;
                M_VALID = (occ_q != 2'd0);
`ifndef FRAME_READER_CHECKSUM_EN
                M_LAST  = M_VALID && (sent_q == LAST_IDX);
`endif
                // Words already buffered plus the one arriving next cycle may never exceed the two slots.
                FIFO_RE = !FIFO_EMPTY && (req_q < LEN) &&
                          (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
                if (FIFO_RE) req_d = req_q + 16'd1;
                if (M_VALID && M_READY) begin
                    sent_d = sent_q + 16'd1;
`ifdef FRAME_READER_CHECKSUM_EN
                    chk_d  = chk_q ^ buf0_q;
                    if (sent_q == LAST_IDX) state_d = S_TRL;
`else
                    if (sent_q == LAST_IDX) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = S_IDLE;
                    end
`endif
                end
            end
`ifdef FRAME_READER_CHECKSUM_EN
            S_TRL: begin
                M_DATA  = chk_q;
                M_VALID = 1'b1;
                M_LAST  = 1'b1;
                if (M_READY) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry skid buffer: buf0 is the head; a word read last cycle is captured this cycle.
    assign pop = (state_q == S_BODY) && (occ_q != 2'd0) && M_READY;

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = FIFO_Q;
                else               buf1_d = FIFO_Q;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = FIFO_Q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = FIFO_Q;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            seq_q      <= '0;
            req_q      <= '0;
            sent_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
`ifdef FRAME_READER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            req_q      <= req_d;
            sent_q     <= sent_d;
            occ_q      <= occ_d;
            inflight_q <= FIFO_RE;
`ifdef FRAME_READER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // NOTE: buffer storage is not reset; occupancy qualifies it and M_DATA is forced to zero outside frames.
    always_ff @(posedge CLK) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign BUSY      = (state_q != S_IDLE);
    assign FRAME_SEQ = seq_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: FRAME_LEN=4 instance with a FIFO model, plus a FRAME_LEN=1 instance.
module tb_fifo_frame_reader;

    localparam int FL = 4;
`ifdef FRAME_READER_CHECKSUM_EN
    localparam int FB  = FL + 2;
    localparam int FB1 = 3;
    localparam bit CHK = 1'b1;
`else
    localparam int FB  = FL + 1;
    localparam int FB1 = 2;
    localparam bit CHK = 1'b0;
`endif

    typedef logic [32:0] beat_t;

    logic        clk = 1'b0;
    logic        rst, enable, m_ready, fifo_empty, fifo_re;
    logic [31:0] fifo_q, m_data;
    logic        m_valid, m_last, busy;
    logic [15:0] frame_seq;

    logic        enable1, fifo_re1, m_valid1, m_last1, busy1;
    logic        m_ready1 = 1'b1;
    logic        fifo_empty1 = 1'b0;
    logic [31:0] q1, m_data1;
    logic [31:0] cnt1 = 32'd100;
    logic [15:0] seq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DATA_WIDTH(32), .FRAME_LEN(FL), .HEADER_TAG(16'hA5A5)) u_dut (
        .CLK(clk), .RESET(rst), .ENABLE(enable), .FIFO_EMPTY(fifo_empty), .FIFO_RE(fifo_re),
        .FIFO_Q(fifo_q), .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready),
        .M_LAST(m_last), .BUSY(busy), .FRAME_SEQ(frame_seq)
    );

    fifo_frame_reader #(.DATA_WIDTH(32), .FRAME_LEN(1), .HEADER_TAG(16'hA5A5)) u_dut1 (
        .CLK(clk), .RESET(rst), .ENABLE(enable1), .FIFO_EMPTY(fifo_empty1), .FIFO_RE(fifo_re1),
        .FIFO_Q(q1), .M_DATA(m_data1), .M_VALID(m_valid1), .M_READY(m_ready1),
        .M_LAST(m_last1), .BUSY(busy1), .FRAME_SEQ(seq1)
    );

    // Standard-mode FIFO model: Q updates on the edge that samples RE.
    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_flush = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_re && !fifo_empty) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_re1) begin
            q1   <= cnt1;
            cnt1 <= cnt1 + 32'd1;
        end
    end

    // Stream monitor, sampling mid-cycle.
    beat_t rx_q[$];
    beat_t exp_q[$];
    int    word_idx = 0, re_cnt = 0, sent_cnt = 0;
    int    viol_stable = 0, viol_outst = 0, viol_empty = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat = '0;

    always @(negedge clk) begin
        if (rst) begin
            word_idx   = 0;
            re_cnt     = 0;
            sent_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || {m_last, m_data} !== prev_beat)) viol_stable++;
            if (fifo_re && fifo_empty) viol_empty++;
            if (fifo_re && (re_cnt - sent_cnt) >= 2) viol_outst++;
            if (fifo_re) re_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
            if (m_valid && m_ready) begin
                rx_q.push_back({m_last, m_data});
                if (word_idx >= 1 && word_idx <= FL) sent_cnt++;
                word_idx = m_last ? 0 : word_idx + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    function automatic void add_frame(input logic [15:0] seq, input logic [31:0] w0, w1, w2, w3);
        logic [31:0] w [4];
        logic [31:0] x;
        w = '{w0, w1, w2, w3};
        x = '0;
        exp_q.push_back({1'b0, 16'hA5A5, seq});
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(!CHK && i == 3), w[i]});
            x ^= w[i];
        end
        if (CHK) exp_q.push_back({1'b1, x});
    endfunction

    // Waits for n beats; ENABLE drops once drop_at beats are in, M_READY optionally toggles.
    task automatic wait_rx(input int n, input int drop_at, input bit toggle, input string what);
        int cyc;
        cyc = 0;
        while (rx_q.size() < n && cyc < 400) begin
            if (rx_q.size() >= drop_at) enable = 1'b0;
            if (toggle) m_ready = ~m_ready;
            step();
            cyc++;
        end
        if (rx_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d beats, required %0d", what, rx_q.size(), n);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; enable1 = 1'b0; m_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if ({fifo_re, m_valid, m_last, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got re/valid/last/busy=%b required 0000", {fifo_re, m_valid, m_last, busy});
        end
        checks++;
        if ({frame_seq, m_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got seq=%h data=%h required 0/0", frame_seq, m_data);
        end
    endtask

    task automatic test_frame_len1();
        beat_t got[$];
        beat_t exp1[$];
        beat_t g;
        int    cyc;
        enable1 = 1'b1;
        cyc = 0;
        while (got.size() < 3 * FB1 && cyc < 100) begin
            if (m_valid1) got.push_back({m_last1, m_data1});
            if (got.size() >= 2 * FB1 + 1) enable1 = 1'b0;
            step();
            cyc++;
        end
        enable1 = 1'b0;
        repeat (5) step();
        for (int k = 0; k < 3; k++) begin
            exp1.push_back({1'b0, 16'hA5A5, 16'(k)});
            exp1.push_back({!CHK, 32'd100 + 32'(k)});
            if (CHK) exp1.push_back({1'b1, 32'd100 + 32'(k)});
        end
        for (int i = 0; i < exp1.size(); i++) begin
            checks++;
            g = (i < got.size()) ? got[i] : 'x;
            if (g !== exp1[i]) begin
                errors++;
                $display("FAIL len1 beat %0d: got %h required %h", i, g, exp1[i]);
            end
        end
        checks++;
        if (cnt1 !== 32'd103 || seq1 !== 16'd3 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_end: got reads=%0d seq=%0d busy=%b required 3/3/0", cnt1 - 32'd100, seq1, busy1);
        end
    endtask

    task automatic test_basic();
        int    r0;
        beat_t g;
        rx_q.delete(); exp_q.delete();
        r0 = re_cnt;
        for (int i = 1; i <= 4; i++) push_word(32'(i));
        enable = 1'b1;
        wait_rx(FB, 1, 1'b0, "basic");
        repeat (3) step();
        add_frame(16'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            g = (i < rx_q.size()) ? rx_q[i] : 'x;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL basic beat %0d: got %h required %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (re_cnt - r0 != FL) begin
            errors++;
            $display("FAIL basic_re_count: got %0d required %0d", re_cnt - r0, FL);
        end
        checks++;
        if (frame_seq !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got seq=%0d busy=%b required 1/0", frame_seq, busy);
        end
    endtask

    task automatic test_back_to_back();
        beat_t g;
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) push_word(32'h1000 + 32'(i));
        enable = 1'b1;
        wait_rx(4 * FB, 3 * FB + 1, 1'b1, "backpressure");
        repeat (3) step();
        for (int f = 0; f < 4; f++)
            add_frame(16'(f + 1), 32'h1000 + 32'(4 * f), 32'h1001 + 32'(4 * f),
                      32'h1002 + 32'(4 * f), 32'h1003 + 32'(4 * f));
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            g = (i < rx_q.size()) ? rx_q[i] : 'x;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL backpressure beat %0d: got %h required %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (viol_stable != 0 || viol_outst != 0) begin
            errors++;
            $display("FAIL backpressure_rules: got stable_viol=%0d outstanding_viol=%0d required 0/0", viol_stable, viol_outst);
        end
        checks++;
        if (frame_seq !== 16'd5) begin
            errors++;
            $display("FAIL backpressure_seq: got %0d required 5", frame_seq);
        end
    endtask

    task automatic test_empty_gap();
        int    vcnt;
        beat_t g;
        rx_q.delete(); exp_q.delete();
        push_word(32'h11); push_word(32'h22);
        enable = 1'b1;
        wait_rx(3, 1, 1'b0, "gap_pre");
        vcnt = 0;
        repeat (20) begin
            step();
            if (m_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_stall: got valid_cycles=%0d busy=%b required 0/1", vcnt, busy);
        end
        push_word(32'h33); push_word(32'h44);
        wait_rx(FB, 1, 1'b0, "gap_post");
        repeat (3) step();
        add_frame(16'd5, 32'h11, 32'h22, 32'h33, 32'h44);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            g = (i < rx_q.size()) ? rx_q[i] : 'x;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL gap beat %0d: got %h required %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (viol_empty != 0) begin
            errors++;
            $display("FAIL gap_re_while_empty: got %0d required 0", viol_empty);
        end
    endtask

    task automatic test_enable_drop();
        int    vcnt;
        beat_t g;
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        enable = 1'b1;
        wait_rx(FB, 2, 1'b0, "drop");
        vcnt = 0;
        repeat (20) begin
            step();
            if (m_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0 || busy !== 1'b0 || rx_q.size() != FB) begin
            errors++;
            $display("FAIL drop_idle: got valid_cycles=%0d busy=%b beats=%0d required 0/0/%0d", vcnt, busy, rx_q.size(), FB);
        end
        enable = 1'b1;
        wait_rx(2 * FB, FB + 1, 1'b0, "drop_resume");
        repeat (3) step();
        add_frame(16'd6, 32'h100, 32'h101, 32'h102, 32'h103);
        add_frame(16'd7, 32'h104, 32'h105, 32'h106, 32'h107);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            g = (i < rx_q.size()) ? rx_q[i] : 'x;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL drop beat %0d: got %h required %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (frame_seq !== 16'd8) begin
            errors++;
            $display("FAIL drop_seq: got %0d required 8", frame_seq);
        end
    endtask

    task automatic test_reset_mid();
        beat_t g;
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
        enable = 1'b1;
        wait_rx(3, 1, 1'b0, "rst_pre");
        rst = 1'b1;
        fifo_flush = 1'b1;
        step();
        checks++;
        if ({fifo_re, m_valid, m_last, busy} !== 4'b0000 || {frame_seq, m_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid: got re/valid/last/busy=%b seq=%h data=%h required 0000/0/0",
                     {fifo_re, m_valid, m_last, busy}, frame_seq, m_data);
        end
        rst = 1'b0;
        fifo_flush = 1'b0;
        step();
        rx_q.delete();
        for (int i = 0; i < 4; i++) push_word(32'h300 + 32'(i));
        enable = 1'b1;
        wait_rx(FB, 1, 1'b0, "rst_post");
        repeat (3) step();
        add_frame(16'd0, 32'h300, 32'h301, 32'h302, 32'h303);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            g = (i < rx_q.size()) ? rx_q[i] : 'x;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_post beat %0d: got %h required %h", i, g, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_len1();
        test_basic();
        test_back_to_back();
        test_empty_gap();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
